lat_stats_collector: RTL and testbench

- Sits directly downstream of the HBM read engine and consumes its latency-sample outputs: lat_timer_valid/lat_timer, end_of_exec and lat_timer_sum.
- Accumulates per-run statistics: count, sum, min, max and total cycles.
- Stores the first SAMPLE_DEPTH raw samples in an on-chip buffer.
- Exposes results to the host-side status path through held registers plus an indexed readback port.

---
 rtl/lat_stats_pkg.sv | 21 ++
 rtl/lat_sample_ram.sv | 31 +++
 rtl/lat_stats_collector.sv | 161 ++++++++++++++++
 tb/tb_lat_stats_collector.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/lat_stats_pkg.sv
// Shared types and helpers for the latency statistics collector.
// Pure declarations: no latency, no backpressure.
package lat_stats_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_DONE
    } state_e;

    localparam int HIST_BINS = 16;
    localparam int RD_DATA_W = 32;

    // Bins above the last one are folded into it so long-tail samples stay visible.
    function automatic logic [3:0] hist_bin(input logic [31:0] lat, input int shift);
        logic [31:0] s;
        s = lat >> shift;
        return (s > 32'd15) ? 4'd15 : s[3:0];
    endfunction

endpackage

// File: rtl/lat_sample_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port.
// Read data 1 cycle after i_re; a same-address read/write returns the old word; no backpressure.
module lat_sample_ram #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_re,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/lat_stats_collector.sv
// Per-run latency statistics (count/sum/min/max/cycles) plus raw-sample buffer; optional LAT_HIST_EN histogram.
// Stats update 1 cycle after each strobe, readback 1 cycle after rd_req; no backpressure (strobe inputs).
module lat_stats_collector
    import lat_stats_pkg::*;
#(
    parameter int SAMPLE_DEPTH = 1024,
    parameter int LAT_WIDTH    = 16,
    parameter int SUM_WIDTH    = 48,
    parameter int CNT_WIDTH    = 32,
    parameter int HIST_SHIFT   = 4,
    localparam int AW          = $clog2(SAMPLE_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 end_of_exec,
    input  logic                 lat_timer_valid,
    input  logic [LAT_WIDTH-1:0] lat_timer,
    input  logic [63:0]          lat_timer_sum,
    output logic                 stat_done,
    output logic [CNT_WIDTH-1:0] stat_count,
    output logic [SUM_WIDTH-1:0] stat_sum,
    output logic [LAT_WIDTH-1:0] stat_min,
    output logic [LAT_WIDTH-1:0] stat_max,
    output logic [63:0]          stat_cycles,
    output logic                 stat_ovf,
    input  logic                 rd_req,
    input  logic                 rd_sel,
    input  logic [AW-1:0]        rd_idx,
    output logic                 rd_valid,
    output logic [RD_DATA_W-1:0] rd_data
);

    state_e               r_state, w_state_nxt;
    logic [CNT_WIDTH-1:0] r_count;
    logic [SUM_WIDTH-1:0] r_sum;
    logic [LAT_WIDTH-1:0] r_min, r_max;
    logic [63:0]          r_cycles;
    logic                 r_ovf;
    logic                 r_rd_valid;
    logic [LAT_WIDTH-1:0] w_ram_q;

    // start overrides any sample or end-of-run arriving in the same cycle
    wire w_accept   = (r_state == ST_COLLECT) && lat_timer_valid && !start;
    wire w_finish   = (r_state == ST_COLLECT) && end_of_exec && !start;
    wire w_buf_room = r_count < CNT_WIDTH'(SAMPLE_DEPTH);
    wire w_cnt_sat  = &r_count;
    wire [SUM_WIDTH:0] w_sum_ext = {1'b0, r_sum} + (SUM_WIDTH+1)'(lat_timer);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (start) begin
            w_state_nxt = ST_COLLECT;
        end else if (w_finish) begin
            w_state_nxt = ST_DONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count  <= '0;
            r_sum    <= '0;
            r_min    <= '1;
            r_max    <= '0;
            r_cycles <= '0;
            r_ovf    <= 1'b0;
        end else if (start) begin
            r_count  <= '0;
            r_sum    <= '0;
            r_min    <= '1;
            r_max    <= '0;
            r_cycles <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_count <= w_cnt_sat ? r_count : r_count + 1'b1;
                r_sum   <= w_sum_ext[SUM_WIDTH] ? '1 : w_sum_ext[SUM_WIDTH-1:0];
                if (lat_timer < r_min) r_min <= lat_timer;
                if (lat_timer > r_max) r_max <= lat_timer;
                if (!w_buf_room || w_cnt_sat || w_sum_ext[SUM_WIDTH]) r_ovf <= 1'b1;
            end
            if (w_finish) begin
                r_cycles <= lat_timer_sum;
            end
        end
    end

    lat_sample_ram #(
        .DEPTH (SAMPLE_DEPTH),
        .WIDTH (LAT_WIDTH)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_accept && w_buf_room),
        .i_waddr (r_count[AW-1:0]),
        .i_wdata (lat_timer),
        .i_re    (rd_req),
        .i_raddr (rd_idx),
        .o_rdata (w_ram_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= rd_req;
        end
    end

`ifdef LAT_HIST_EN
    logic [31:0] r_hist [HIST_BINS];
    logic [31:0] r_hist_q;
    logic        r_rd_sel;
    logic [AW+3:0] w_idx_ext;
    logic [3:0]    w_bin;

    assign w_idx_ext = {4'b0, rd_idx};
    assign w_bin     = hist_bin(32'(lat_timer), HIST_SHIFT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < HIST_BINS; i++) r_hist[i] <= '0;
            r_hist_q <= '0;
            r_rd_sel <= 1'b0;
        end else begin
            if (start) begin
                for (int i = 0; i < HIST_BINS; i++) r_hist[i] <= '0;
            end else if (w_accept && !(&r_hist[w_bin])) begin
                r_hist[w_bin] <= r_hist[w_bin] + 1'b1;
            end
            if (rd_req) begin
                r_hist_q <= r_hist[w_idx_ext[3:0]];
                r_rd_sel <= rd_sel;
            end
        end
    end

    assign rd_data = !r_rd_valid ? '0 :
                     r_rd_sel    ? r_hist_q : RD_DATA_W'(w_ram_q);
`else
    wire w_unused = rd_sel ^ (HIST_SHIFT == 0);
    assign rd_data = r_rd_valid ? RD_DATA_W'(w_ram_q) : '0;
`endif

    assign rd_valid    = r_rd_valid;
    assign stat_done   = (r_state == ST_DONE);
    assign stat_count  = r_count;
    assign stat_sum    = r_sum;
    assign stat_min    = (r_count == '0) ? '0 : r_min;
    assign stat_max    = r_max;
    assign stat_cycles = r_cycles;
    assign stat_ovf    = r_ovf;

endmodule

// File: tb/tb_lat_stats_collector.sv
// Scoreboard bench for lat_stats_collector: stimulus queues expected stats/readback words, a monitor checks them.
module tb_lat_stats_collector;

`ifdef LAT_HIST_EN
    localparam int TB_DEPTH = 16;
`else
    localparam int TB_DEPTH = 4;
`endif
    localparam int AW = $clog2(TB_DEPTH);

    typedef struct {
        logic [31:0] cnt;
        logic [47:0] sum;
        logic [15:0] mn;
        logic [15:0] mx;
        logic [63:0] cyc;
        logic        ovf;
    } st_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0, end_of_exec = 1'b0, lat_timer_valid = 1'b0;
    logic [15:0]   lat_timer = '0;
    logic [63:0]   lat_timer_sum = '0;
    logic          stat_done, stat_ovf;
    logic [31:0]   stat_count;
    logic [47:0]   stat_sum;
    logic [15:0]   stat_min, stat_max;
    logic [63:0]   stat_cycles;
    logic          rd_req = 1'b0, rd_sel = 1'b0;
    logic [AW-1:0] rd_idx = '0;
    logic          rd_valid;
    logic [31:0]   rd_data;

    int n_tests = 0;
    int n_fail  = 0;
    st_t         q_st[$];
    logic [31:0] q_rd[$];

    always #5 clk = ~clk;

    lat_stats_collector #(.SAMPLE_DEPTH(TB_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .end_of_exec(end_of_exec),
        .lat_timer_valid(lat_timer_valid), .lat_timer(lat_timer), .lat_timer_sum(lat_timer_sum),
        .stat_done(stat_done), .stat_count(stat_count), .stat_sum(stat_sum),
        .stat_min(stat_min), .stat_max(stat_max), .stat_cycles(stat_cycles), .stat_ovf(stat_ovf),
        .rd_req(rd_req), .rd_sel(rd_sel), .rd_idx(rd_idx), .rd_valid(rd_valid), .rd_data(rd_data)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // one cycle of strobes, applied at a falling edge and removed at the next
    task automatic cyc(input logic s, input logic v, input logic [15:0] l,
                       input logic e, input logic [63:0] cs);
        start = s; lat_timer_valid = v; lat_timer = l; end_of_exec = e; lat_timer_sum = cs;
        @(negedge clk);
        start = 1'b0; lat_timer_valid = 1'b0; end_of_exec = 1'b0;
    endtask

    task automatic finish_run(input logic [63:0] cs, input st_t exp);
        q_st.push_back(exp);
        cyc(1'b0, 1'b0, 16'd0, 1'b1, cs);
    endtask

    task automatic rd(input logic sel, input int idx, input logic [31:0] exp);
        q_rd.push_back(exp);
        rd_req = 1'b1; rd_sel = sel; rd_idx = AW'(idx);
        @(negedge clk);
        rd_req = 1'b0;
    endtask

    // monitor: stats checked when stat_done rises, readback checked on rd_valid
    initial begin : monitor
        logic prev_done;
        st_t  e;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rd_valid) begin
                if (q_rd.size() == 0) check("rd_unexpected", 64'(rd_data), 64'hFFFF_FFFF_FFFF_FFFF);
                else check("rd_data", 64'(rd_data), 64'(q_rd.pop_front()));
            end
            if (stat_done && !prev_done) begin
                if (q_st.size() == 0) begin
                    check("done_unexpected", 64'(stat_done), 64'd0);
                end else begin
                    e = q_st.pop_front();
                    check("count",  64'(stat_count), 64'(e.cnt));
                    check("sum",    64'(stat_sum),   64'(e.sum));
                    check("min",    64'(stat_min),   64'(e.mn));
                    check("max",    64'(stat_max),   64'(e.mx));
                    check("cycles", stat_cycles,     e.cyc);
                    check("ovf",    64'(stat_ovf),   64'(e.ovf));
                end
            end
            prev_done = stat_done;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int n;
        repeat (3) @(negedge clk);
        check("rst_done",  64'(stat_done),  64'd0);
        check("rst_count", 64'(stat_count), 64'd0);
        check("rst_min",   64'(stat_min),   64'd0);
        check("rst_rdv",   64'(rd_valid),   64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // basic run
        cyc(1'b1, 1'b0, 16'd0, 1'b0, 64'd0);
        cyc(1'b0, 1'b1, 16'd10, 1'b0, 64'd0);
        cyc(1'b0, 1'b1, 16'd30, 1'b0, 64'd0);
        cyc(1'b0, 1'b1, 16'd20, 1'b0, 64'd0);
        finish_run(64'd500, '{cnt: 3, sum: 60, mn: 10, mx: 30, cyc: 500, ovf: 0});
        rd(1'b0, 0, 32'd10);
        rd(1'b0, 1, 32'd30);
        rd(1'b0, 2, 32'd20);
        // strobes in ST_DONE must not disturb held results
        cyc(1'b0, 1'b1, 16'd50, 1'b1, 64'd777);
        @(negedge clk);
        check("done_hold_count",  64'(stat_count), 64'd3);
        check("done_hold_cycles", stat_cycles,     64'd500);

        // empty run
        cyc(1'b1, 1'b0, 16'd0, 1'b0, 64'd0);
        finish_run(64'd7, '{cnt: 0, sum: 0, mn: 0, mx: 0, cyc: 7, ovf: 0});

        // buffer overflow: TB_DEPTH+2 samples of 1..n
        n = TB_DEPTH + 2;
        cyc(1'b1, 1'b0, 16'd0, 1'b0, 64'd0);
        for (int i = 1; i <= n; i++) cyc(1'b0, 1'b1, 16'(i), 1'b0, 64'd0);
        finish_run(64'd100, '{cnt: 32'(n), sum: 48'(n * (n + 1) / 2), mn: 1, mx: 16'(n), cyc: 100, ovf: 1});
        for (int i = 0; i < TB_DEPTH; i++) rd(1'b0, i, 32'(i + 1));

        // collisions: start beats a sample; end-of-run includes its sample
        cyc(1'b1, 1'b1, 16'd99, 1'b0, 64'd0);
        @(negedge clk);
        check("start_coll_count", 64'(stat_count), 64'd0);
        q_st.push_back('{cnt: 1, sum: 7, mn: 7, mx: 7, cyc: 42, ovf: 0});
        cyc(1'b0, 1'b1, 16'd7, 1'b1, 64'd42);
        rd(1'b0, 0, 32'd7);

        // asynchronous reset mid-run
        cyc(1'b1, 1'b0, 16'd0, 1'b0, 64'd0);
        cyc(1'b0, 1'b1, 16'd11, 1'b0, 64'd0);
        cyc(1'b0, 1'b1, 16'd12, 1'b0, 64'd0);
        check("pre_rst_count", 64'(stat_count), 64'd2);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_count", 64'(stat_count), 64'd0);
        check("arst_sum",   64'(stat_sum),   64'd0);
        check("arst_max",   64'(stat_max),   64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        cyc(1'b1, 1'b0, 16'd0, 1'b0, 64'd0);
        cyc(1'b0, 1'b1, 16'd5, 1'b0, 64'd0);
        finish_run(64'd3, '{cnt: 1, sum: 5, mn: 5, mx: 5, cyc: 3, ovf: 0});

`ifdef LAT_HIST_EN
        cyc(1'b1, 1'b0, 16'd0, 1'b0, 64'd0);
        cyc(1'b0, 1'b1, 16'd5, 1'b0, 64'd0);
        cyc(1'b0, 1'b1, 16'd17, 1'b0, 64'd0);
        cyc(1'b0, 1'b1, 16'd300, 1'b0, 64'd0);
        finish_run(64'd9, '{cnt: 3, sum: 322, mn: 5, mx: 300, cyc: 9, ovf: 0});
        rd(1'b1, 0, 32'd1);
        rd(1'b1, 1, 32'd1);
        rd(1'b1, 2, 32'd0);
        rd(1'b1, 15, 32'd1);
`endif

        repeat (4) @(negedge clk);
        check("st_queue_drained", 64'(q_st.size()), 64'd0);
        check("rd_queue_drained", 64'(q_rd.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
